spi_frame_seq: RTL and testbench
================================

Name: spi_frame_seq

Overview:
- Upstream command sequencer for the 40-bit SPI master in the stepper-driver datapath.
- Accepts register read/write requests over a valid/ready handshake and packs each into a 40-bit datagram: bit 39 = write flag, bits 38:32 = address, bits 31:0 = data.
- Holds the master's send-enable level for one frame, then drops it for a gap, and captures the returned datagram.
- Reads use two frames because driver read data is returned one frame late.

Parameters:
- DATA_W, 32, register payload width.
- ADDR_W, 7, register address width.
- FRAME_W, 40, datagram width (= 1 + ADDR_W + DATA_W).
- CNT_W, 16, width of the frame-length counter.
- GAP_CYCLES, 8, clk_in cycles with send-enable low between frames; must cover at least two SPI-divided clock periods.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, reset; asynchronous, active-high.
- req_valid_in, input, 1, request valid.
- req_ready_out, output, 1, request accepted when high together with req_valid_in.
- req_write_in, input, 1, 1 = write, 0 = read.
- req_addr_in, input, ADDR_W, register address.
- req_data_in, input, DATA_W, write data; ignored for reads.
- frame_cycles_in, input, CNT_W, clk_in cycles send-enable is held per frame; sampled at request accept.
- spi_data_out, output, FRAME_W, datagram to the SPI master's parallel input.
- spi_send_enable_out, output, 1, frame enable to the SPI master.
- spi_data_in, input, FRAME_W, received datagram from the SPI master.
- rsp_valid_out, output, 1, response valid.
- rsp_ready_in, input, 1, response consumed.
- rsp_status_out, output, 8, status byte (spi_data_in[39:32] of the final frame).
- rsp_data_out, output, DATA_W, returned data (spi_data_in[31:0] of the final frame).
- rsp_mismatch_out, output, 1, write-verify mismatch flag.
- busy_out, output, 1, high whenever state is not IDLE.

Behaviour:
- Reset values:
  - State = IDLE.
  - All outputs 0, except req_ready_out = 1.
  - spi_send_enable_out drops immediately on rst_in; there is no clock dependency.
- States and transitions:
  - IDLE: req_ready_out = 1. On req_valid_in && req_ready_out, latch write, addr, data and frame length (frame_cycles_in; a value of 0 is treated as 1). Clear the frame index. Go to SEND next cycle.
  - SEND: spi_send_enable_out = 1 and spi_data_out = latched datagram. The counter runs from 1 to the latched length. On the cycle the counter equals the length, latch spi_data_in into the capture register and go to GAP. send-enable is therefore high for exactly length cycles.
  - GAP: send-enable = 0 for GAP_CYCLES cycles. Afterwards:
    - If more frames remain (read frame 0, or the verify frame), increment the frame index and go to SEND.
    - Otherwise go to RESP.
  - RESP: rsp_valid_out = 1, with status, data and mismatch taken from the capture register. Hold all of them stable until rsp_ready_in. When rsp_valid_out && rsp_ready_in, go to IDLE; req_ready_out returns to 1 the following cycle.
- Frame counts:
  - Write: 1 frame.
  - Read: 2 identical frames {0, addr, 0}; the response comes from frame 2.
- spi_data_out is registered and stable for the entire SEND and GAP duration. It changes only on entry to SEND.
- req_ready_out = 0 in all states other than IDLE. Requests presented while busy are not accepted and must be held by the source.
- A change to frame_cycles_in mid-transaction has no effect until the next accept.
- rsp_ready_in asserted outside RESP is ignored.
- Minimum latency, write, accept to rsp_valid_out: 1 + L + GAP_CYCLES cycles.
- Minimum latency, read, accept to rsp_valid_out: 1 + 2·(L + GAP_CYCLES) cycles.
- Reset mid-frame: the transaction is abandoned with no response, and the state returns to IDLE.

Optional Feature:
- Macro: SPI_WRITE_VERIFY_EN.
- Defined:
  - A write gets two extra frames: a read of the same address, then that read repeated. The write costs 3 frames total.
  - rsp_data_out = data from the final frame.
  - rsp_mismatch_out = 1 when the final data differs from the latched write data; it is always 0 for reads.
- Undefined: writes use 1 frame and rsp_mismatch_out is tied to 0.

Decomposition:
- Package spi_seq_pkg holds:
  - the state enum: IDLE, SEND, GAP, RESP;
  - the datagram field positions: WR_BIT = 39, ADDR_MSB/LSB = 38/32, DATA_MSB/LSB = 31/0;
  - a helper function that packs {write, addr, data}.
- One sub-module, seq_timer: a loadable down-counter with a done pulse. It is shared by SEND (load = frame length) and GAP (load = GAP_CYCLES).

Test Plan:
- Write: L = 20, write addr 0x6C, data 0x00010203 -> spi_data_out = 0xEC00010203 and send-enable high exactly 20 cycles. With spi_data_in = 0x0512345678, response is status 0x05 and data 0x12345678 after 29 cycles (1 + 20 + 8).
- Read: L = 20, read addr 0x01 -> two frames of 0x0100000000, each 20 cycles high with an 8-cycle low gap between them. The response carries the capture from frame 2 (0x01DEADBEEF), not frame 1.
- Backpressure: hold rsp_ready_in low for 10 cycles -> rsp_valid_out and rsp_data_out stay stable. A second request held valid throughout is accepted only after the handshake; req_ready_out stays 0 until then.
- Boundary: frame_cycles_in = 0 -> send-enable high exactly 1 cycle. A frame_cycles_in change during SEND does not alter the current frame length.
- Reset: assert rst_in on SEND cycle 5 -> spi_send_enable_out = 0 immediately, no rsp_valid_out, req_ready_out = 1 after release. The next request proceeds normally.
- With SPI_WRITE_VERIFY_EN: write data 0x11, final read returns 0x10 -> three frames and rsp_mismatch_out = 1. Returning 0x11 instead -> rsp_mismatch_out = 0.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: widths, datagram field positions, FSM states and the datagram packer for spi_frame_seq
package spi_seq_pkg;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 7;
    localparam int FRAME_W    = 1 + ADDR_W + DATA_W;
    localparam int CNT_W      = 16;
    localparam int GAP_CYCLES = 8;
    localparam int WR_BIT     = 39;
    localparam int ADDR_MSB   = 38;
    localparam int ADDR_LSB   = 32;
    localparam int DATA_MSB   = 31;
    localparam int DATA_LSB   = 0;
    typedef enum logic [1:0] {IDLE, SEND, GAP, RESP} state_t;
    function automatic logic [FRAME_W-1:0] pack_frame(input logic wr, input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] data);
        return {wr, addr, data};
    endfunction
endpackage

// File: rtl/spi_frame_seq_if.sv
// spi_frame_seq_if: request/response handshake and SPI-master parallel signals of the frame sequencer
interface spi_frame_seq_if;
    import spi_seq_pkg::*;
    logic               req_valid_in;
    logic               req_ready_out;
    logic               req_write_in;
    logic [ADDR_W-1:0]  req_addr_in;
    logic [DATA_W-1:0]  req_data_in;
    logic [CNT_W-1:0]   frame_cycles_in;
    logic [FRAME_W-1:0] spi_data_out;
    logic               spi_send_enable_out;
    logic [FRAME_W-1:0] spi_data_in;
    logic               rsp_valid_out;
    logic               rsp_ready_in;
    logic [7:0]         rsp_status_out;
    logic [DATA_W-1:0]  rsp_data_out;
    logic               rsp_mismatch_out;
    logic               busy_out;
    modport slave (
        input  req_valid_in, req_write_in, req_addr_in, req_data_in, frame_cycles_in, spi_data_in, rsp_ready_in,
        output req_ready_out, spi_data_out, spi_send_enable_out, rsp_valid_out, rsp_status_out, rsp_data_out,
               rsp_mismatch_out, busy_out
    );
    modport master (
        output req_valid_in, req_write_in, req_addr_in, req_data_in, frame_cycles_in, spi_data_in, rsp_ready_in,
        input  req_ready_out, spi_data_out, spi_send_enable_out, rsp_valid_out, rsp_status_out, rsp_data_out,
               rsp_mismatch_out, busy_out
    );
endinterface

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter whose done output is high on the last counted cycle
module seq_timer
    import spi_seq_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign done = cnt == CNT_W'(1);
endmodule

// File: rtl/spi_frame_seq.sv
// spi_frame_seq: packs register requests into 40-bit SPI frames with timed send-enable and gaps.
// SPI_WRITE_VERIFY_EN adds a two-frame read-back after each write and flags data mismatches.
module spi_frame_seq
    import spi_seq_pkg::*;
(
    input logic            clk_in,
    input logic            rst_in,
    spi_frame_seq_if.slave bus
);
    state_t             state;
    logic               wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic [CNT_W-1:0]   len_q, len_in, t_val;
    logic [1:0]         idx_q, last_idx;
    logic [FRAME_W-1:0] cap_q;
    logic               accept, more, mism, t_load, t_done;

    assign accept = state == IDLE && bus.req_valid_in && bus.req_ready_out;
    assign len_in = bus.frame_cycles_in == '0 ? CNT_W'(1) : bus.frame_cycles_in;
`ifdef SPI_WRITE_VERIFY_EN
    assign last_idx = wr_q ? 2'd2 : 2'd1;
    assign mism     = wr_q && cap_q[DATA_MSB:DATA_LSB] != data_q;
`else
    assign last_idx = wr_q ? 2'd0 : 2'd1;
    assign mism     = 1'b0;
`endif
    assign more   = idx_q != last_idx;
    assign t_load = accept || (t_done && (state == SEND || (state == GAP && more)));
    assign t_val  = state == SEND ? CNT_W'(GAP_CYCLES) : state == IDLE ? len_in : len_q;

    seq_timer u_timer (.clk_in, .rst_in, .load(t_load), .load_val(t_val), .done(t_done));

    // reads return data one frame late, so every read frame is the same {0, addr, 0}
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state                   <= IDLE;
            wr_q                    <= 1'b0;
            addr_q                  <= '0;
            data_q                  <= '0;
            len_q                   <= '0;
            idx_q                   <= '0;
            cap_q                   <= '0;
            bus.req_ready_out       <= 1'b1;
            bus.busy_out            <= 1'b0;
            bus.spi_send_enable_out <= 1'b0;
            bus.spi_data_out        <= '0;
            bus.rsp_valid_out       <= 1'b0;
            bus.rsp_status_out      <= '0;
            bus.rsp_data_out        <= '0;
            bus.rsp_mismatch_out    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    state                   <= SEND;
                    wr_q                    <= bus.req_write_in;
                    addr_q                  <= bus.req_addr_in;
                    data_q                  <= bus.req_data_in;
                    len_q                   <= len_in;
                    idx_q                   <= '0;
                    bus.req_ready_out       <= 1'b0;
                    bus.busy_out            <= 1'b1;
                    bus.spi_send_enable_out <= 1'b1;
                    bus.spi_data_out        <= pack_frame(bus.req_write_in, bus.req_addr_in,
                                                          bus.req_write_in ? bus.req_data_in : '0);
                end
                SEND: if (t_done) begin
                    state                   <= GAP;
                    cap_q                   <= bus.spi_data_in;
                    bus.spi_send_enable_out <= 1'b0;
                end
                GAP: if (t_done) begin
                    if (more) begin
                        state                   <= SEND;
                        idx_q                   <= idx_q + 1'b1;
                        bus.spi_send_enable_out <= 1'b1;
                        bus.spi_data_out        <= pack_frame(1'b0, addr_q, '0);
                    end else begin
                        state                <= RESP;
                        bus.rsp_valid_out    <= 1'b1;
                        bus.rsp_status_out   <= cap_q[WR_BIT:ADDR_LSB];
                        bus.rsp_data_out     <= cap_q[DATA_MSB:DATA_LSB];
                        bus.rsp_mismatch_out <= mism;
                    end
                end
                RESP: if (bus.rsp_ready_in) begin
                    state             <= IDLE;
                    bus.rsp_valid_out <= 1'b0;
                    bus.req_ready_out <= 1'b1;
                    bus.busy_out      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_frame_seq.sv
// tb_spi_frame_seq: directed and random transactions checked against a frame-list model of the sequencer
module tb_spi_frame_seq;
    localparam int G = 8;
`ifdef SPI_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   tests  = 0;
    int   fails  = 0;

    spi_frame_seq_if bus();
    spi_frame_seq dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus.slave));

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic run_txn(input bit wr, input logic [6:0] a, input logic [31:0] d, input logic [15:0] len,
                           input logic [39:0] r0, input logic [39:0] r1, input logic [39:0] r2,
                           input int bp, input bit keep);
        logic [39:0] rep [3];
        logic [39:0] exp_f[$];
        logic [39:0] got_f[$];
        int          lens[$];
        int          gaps[$];
        int          n, nf, el, cur, gap, exp_lat;
        bit          prev, stable, busy_ok, bp_ok;
        logic [39:0] dout, last_rep;
        logic [7:0]  st0;
        logic [31:0] dt0;
        rep[0] = r0;
        rep[1] = r1;
        rep[2] = r2;
        el = (len == 16'd0) ? 1 : int'(len);
        if (wr) exp_f.push_back({1'b1, a, d});
        if (!wr || VERIFY) begin
            exp_f.push_back({1'b0, a, 32'h0});
            exp_f.push_back({1'b0, a, 32'h0});
        end
        nf       = exp_f.size();
        exp_lat  = 1 + nf * (el + G);
        last_rep = rep[nf-1];
        bus.req_write_in    = wr;
        bus.req_addr_in     = a;
        bus.req_data_in     = d;
        bus.frame_cycles_in = len;
        bus.req_valid_in    = 1'b1;
        n = 0;
        while (!bus.req_ready_out && n < 5000) begin
            step();
            n++;
        end
        chk("accept_wait", 64'(n < 5000), 64'(1));
        step();
        bus.req_valid_in    = keep;
        bus.frame_cycles_in = 16'($urandom_range(0, 40));
        n = 1; prev = 1'b0; stable = 1'b1; busy_ok = 1'b1; cur = 0; gap = 0; dout = '0;
        while (!bus.rsp_valid_out && n < 5000) begin
            if (bus.spi_send_enable_out) begin
                if (!prev) begin
                    if (got_f.size() > 0) gaps.push_back(gap);
                    got_f.push_back(bus.spi_data_out);
                    dout = bus.spi_data_out;
                    cur  = 0;
                end
                cur++;
                bus.spi_data_in = (got_f.size() <= 3) ? rep[got_f.size()-1] : 40'h0;
            end else begin
                if (prev) begin
                    lens.push_back(cur);
                    gap = 0;
                end
                gap++;
            end
            if (got_f.size() > 0 && bus.spi_data_out !== dout) stable = 1'b0;
            if (bus.req_ready_out !== 1'b0 || bus.busy_out !== 1'b1) busy_ok = 1'b0;
            prev = bus.spi_send_enable_out;
            bus.rsp_ready_in = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        bus.rsp_ready_in = 1'b0;
        chk("latency", 64'(n), 64'(exp_lat));
        chk("nframes", 64'(got_f.size()), 64'(nf));
        foreach (exp_f[i]) if (i < got_f.size()) chk("frame_word", 64'(got_f[i]), 64'(exp_f[i]));
        chk("nlens", 64'(lens.size()), 64'(nf));
        foreach (lens[i]) chk("enable_len", 64'(lens[i]), 64'(el));
        foreach (gaps[i]) chk("gap_len", 64'(gaps[i]), 64'(G));
        chk("gap_last", 64'(gap), 64'(G));
        chk("dout_stable", 64'(stable), 64'(1));
        chk("busy_ready", 64'(busy_ok), 64'(1));
        chk("rsp_status", 64'(bus.rsp_status_out), 64'(last_rep[39:32]));
        chk("rsp_data", 64'(bus.rsp_data_out), 64'(last_rep[31:0]));
        chk("rsp_mismatch", 64'(bus.rsp_mismatch_out), 64'(VERIFY && wr && last_rep[31:0] != d));
        st0 = bus.rsp_status_out;
        dt0 = bus.rsp_data_out;
        bp_ok = 1'b1;
        for (int i = 0; i < bp; i++) begin
            step();
            if (bus.rsp_valid_out !== 1'b1 || bus.rsp_data_out !== dt0 || bus.rsp_status_out !== st0 ||
                bus.req_ready_out !== 1'b0) bp_ok = 1'b0;
        end
        chk("backpressure", 64'(bp_ok), 64'(1));
        bus.rsp_ready_in = 1'b1;
        step();
        bus.rsp_ready_in = 1'b0;
        chk("rsp_drop", 64'(bus.rsp_valid_out), 64'(0));
        chk("ready_back", 64'(bus.req_ready_out), 64'(1));
    endtask

    initial begin
        bit ok;
        bus.req_valid_in    = 1'b0;
        bus.req_write_in    = 1'b0;
        bus.req_addr_in     = '0;
        bus.req_data_in     = '0;
        bus.frame_cycles_in = '0;
        bus.spi_data_in     = '0;
        bus.rsp_ready_in    = 1'b0;
        step();
        step();
        chk("rst_ready", 64'(bus.req_ready_out), 64'(1));
        chk("rst_enable", 64'(bus.spi_send_enable_out), 64'(0));
        chk("rst_valid", 64'(bus.rsp_valid_out), 64'(0));
        chk("rst_busy", 64'(bus.busy_out), 64'(0));
        chk("rst_dout", 64'(bus.spi_data_out), 64'(0));
        rst_in = 1'b0;
        step();

        run_txn(1'b1, 7'h6C, 32'h0001_0203, 16'd20, 40'h05_1234_5678, 40'h05_1234_5678, 40'h05_1234_5678, 0, 1'b0);
        run_txn(1'b0, 7'h01, 32'h0, 16'd20, 40'h02_1111_1111, 40'h01_DEAD_BEEF, 40'h0, 10, 1'b1);
        run_txn(1'b0, 7'h01, 32'h0, 16'd0, 40'h03_0000_0001, 40'h04_0000_0002, 40'h0, 2, 1'b0);
        run_txn(1'b1, 7'h22, 32'h11, 16'd4, 40'h00_0000_0011, 40'h00_0000_0010, 40'h00_0000_0010, 1, 1'b0);
        run_txn(1'b1, 7'h22, 32'h11, 16'd3, 40'h00_0000_0011, 40'h00_0000_0011, 40'h00_0000_0011, 0, 1'b0);

        bus.req_write_in    = 1'b1;
        bus.req_addr_in     = 7'h15;
        bus.req_data_in     = 32'hCAFE_F00D;
        bus.frame_cycles_in = 16'd20;
        bus.req_valid_in    = 1'b1;
        step();
        bus.req_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("pre_rst_enable", 64'(bus.spi_send_enable_out), 64'(1));
        rst_in = 1'b1;
        #1;
        chk("rst_async_enable", 64'(bus.spi_send_enable_out), 64'(0));
        chk("rst_async_busy", 64'(bus.busy_out), 64'(0));
        step();
        step();
        rst_in = 1'b0;
        chk("rst_release_ready", 64'(bus.req_ready_out), 64'(1));
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.rsp_valid_out !== 1'b0 || bus.spi_send_enable_out !== 1'b0) ok = 1'b0;
        end
        chk("abandoned_quiet", 64'(ok), 64'(1));
        run_txn(1'b0, 7'h15, 32'h0, 16'd6, 40'h07_0000_0000, 40'h08_1234_0000, 40'h0, 0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            bit          wr;
            logic [31:0] d;
            logic [39:0] r2;
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            r2 = {8'($urandom), $urandom};
            if ($urandom_range(0, 1) == 1) r2[31:0] = d;
            run_txn(wr, 7'($urandom), d, 16'($urandom_range(0, 24)), {8'($urandom), $urandom},
                    {8'($urandom), $urandom}, r2, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end
        bus.req_valid_in = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
